// File: rtl/fir_stream_driver_pkg.sv
// Shared definitions for the FIR streaming datapath: FSM encodings,
// counter sizing and the default filter harness parameters.
package fir_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_FLUSH  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    STREAM = ST_STREAM,
    FLUSH  = ST_FLUSH
  } state_t;

  localparam int FIR_DATA_WIDTH = 16;
  localparam int FIR_NUM_TAPS   = 16;
  localparam int FIR_CNT_WIDTH  = 32;

  // Counter must reach NUM_TAPS-1 (load) and NUM_TAPS-2 (flush).
  function automatic int cnt_width(input int num_taps);
    return $clog2(num_taps) + 1;
  endfunction

endpackage

// File: rtl/fir_stream_driver_if.sv
// Host-side coefficient and sample streams (ready/valid).
// master = host, slave = fir_stream_driver.
interface fir_stream_driver_if
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
);
  logic                  coeff_s_valid;
  logic                  coeff_s_ready;
  logic [DATA_WIDTH-1:0] coeff_s_data;
  logic                  samp_s_valid;
  logic                  samp_s_ready;
  logic [DATA_WIDTH-1:0] samp_s_data;
  logic                  samp_s_last;

  modport master (
    output coeff_s_valid, coeff_s_data,
    output samp_s_valid, samp_s_data, samp_s_last,
    input  coeff_s_ready, samp_s_ready
  );

  modport slave (
    input  coeff_s_valid, coeff_s_data,
    input  samp_s_valid, samp_s_data, samp_s_last,
    output coeff_s_ready, samp_s_ready
  );
endinterface

// File: rtl/fir_stream_driver.sv
// Upstream driver for fir_filter: loads NUM_TAPS coefficients per load
// command, streams a sample frame, then flushes NUM_TAPS-1 zero samples
// so the convolution tail drains out of the filter.
module fir_stream_driver
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int NUM_TAPS   = FIR_NUM_TAPS,
  parameter int CNT_WIDTH  = FIR_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_load,
  fir_stream_driver_if.slave    s,
  output logic                  coeff_valid,
  output logic [DATA_WIDTH-1:0] coeff_in,
  output logic                  input_valid,
  output logic [DATA_WIDTH-1:0] x,
  output logic                  busy,
  output logic                  load_done,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_len
);

  localparam int CW = cnt_width(NUM_TAPS);
  localparam logic [CW-1:0] LOAD_LAST  = CW'(NUM_TAPS - 1);
  // Only meaningful for NUM_TAPS >= 2; a single-tap filter never flushes.
  localparam logic [CW-1:0] FLUSH_LAST = CW'((NUM_TAPS >= 2) ? NUM_TAPS - 2 : 0);

  state_t        state;
  logic [CW-1:0] cnt;

  // Ready depends on state only, never on the upstream valid.
  assign s.coeff_s_ready = (state == LOAD);
  assign s.samp_s_ready  = (state == STREAM);
  assign busy            = (state != IDLE);

  // Control FSM with registered filter-side outputs and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_len   <= '0;
      coeff_valid <= 1'b0;
      coeff_in    <= '0;
      input_valid <= 1'b0;
      x           <= '0;
      load_done   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      coeff_valid <= 1'b0;
      input_valid <= 1'b0;
      load_done   <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          // Load takes priority; a pending sample only opens the frame,
          // the first beat is accepted once in STREAM.
          if (cfg_load) begin
            state <= LOAD;
            cnt   <= '0;
          end else if (s.samp_s_valid) begin
            state     <= STREAM;
            frame_len <= '0;
          end
        end
        LOAD: begin
          if (s.coeff_s_valid) begin
            coeff_valid <= 1'b1;
            coeff_in    <= s.coeff_s_data;
            cnt         <= cnt + 1'b1;
            if (cnt == LOAD_LAST) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (s.samp_s_valid) begin
            input_valid <= 1'b1;
            x           <= s.samp_s_data;
            if (frame_len != {CNT_WIDTH{1'b1}})
              frame_len <= frame_len + CNT_WIDTH'(1);
            if (s.samp_s_last) begin
              if (NUM_TAPS == 1) begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end else begin
                state <= FLUSH;
                cnt   <= '0;
              end
            end
          end
        end
        FLUSH: begin
          input_valid <= 1'b1;
          x           <= '0;
          cnt         <= cnt + 1'b1;
          if (cnt == FLUSH_LAST) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Bench for fir_stream_driver: a 4-tap instance (narrow frame_len so
// saturation is reachable) and a 1-tap instance. A stand-in filter
// model consumes the driver outputs; expectations come from plain
// convolution of the host-side coefficients and samples.
module tb_fir_stream_driver;
  import fir_pkg::*;

  localparam int DW  = 16;
  localparam int N   = 4;
  localparam int FW  = 3;
  localparam int FW1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, cfg4, rst1, cfg1;
  fir_stream_driver_if #(.DATA_WIDTH(DW)) h4 ();
  fir_stream_driver_if #(.DATA_WIDTH(DW)) h1 ();

  logic          cv4, iv4, busy4, ld4, fd4;
  logic [DW-1:0] ci4, x4;
  logic [FW-1:0] fl4;
  logic          cv1, iv1, busy1, ld1, fd1;
  logic [DW-1:0] ci1, x1;
  logic [FW1-1:0] fl1;

  fir_stream_driver #(.DATA_WIDTH(DW), .NUM_TAPS(N), .CNT_WIDTH(FW)) dut4 (
    .clk(clk), .reset(rst4), .cfg_load(cfg4), .s(h4),
    .coeff_valid(cv4), .coeff_in(ci4), .input_valid(iv4), .x(x4),
    .busy(busy4), .load_done(ld4), .frame_done(fd4), .frame_len(fl4));

  fir_stream_driver #(.DATA_WIDTH(DW), .NUM_TAPS(1), .CNT_WIDTH(FW1)) dut1 (
    .clk(clk), .reset(rst1), .cfg_load(cfg1), .s(h1),
    .coeff_valid(cv1), .coeff_in(ci1), .input_valid(iv1), .x(x1),
    .busy(busy1), .load_done(ld1), .frame_done(fd1), .frame_len(fl1));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor + stand-in filter for dut4 ----------------
  int cyc = 0;
  int cq[$], ccyc[$], xq[$], xcyc[$], fd_at[$], yq[$];
  int ld_at = 0;
  int orphan = 0;
  int cr_seen = 0;
  bit watch_cr = 0;
  int hf[N] = '{default: 0};
  int xd[N] = '{default: 0};
  int ht[N] = '{default: 0};

  initial forever begin
    @(negedge clk);
    cyc++;
    if (cv4) begin
      for (int k = N - 1; k > 0; k--) hf[k] = hf[k-1];
      hf[0] = int'(ci4);
      cq.push_back(int'(ci4));
      ccyc.push_back(cyc);
    end
    if (ld4) begin
      if (cv4) ld_at = cq.size();
      else orphan++;
    end
    if (iv4) begin
      int y;
      for (int k = N - 1; k > 0; k--) xd[k] = xd[k-1];
      xd[0] = int'(x4);
      y = 0;
      for (int k = 0; k < N; k++) y += hf[k] * xd[k];
      yq.push_back(y);
      xq.push_back(int'(x4));
      xcyc.push_back(cyc);
      if (fd4) fd_at.push_back(xq.size());
    end else if (fd4) begin
      orphan++;
    end
    if (watch_cr && h4.coeff_s_ready) cr_seen++;
  end

  task automatic wait_c();
    int t = 0;
    forever begin
      @(negedge clk);
      if (h4.coeff_s_ready) break;
      if (++t > 20) begin chk("coeff_ready_timeout", 0, 1); break; end
    end
    tick();
  endtask

  task automatic wait_s();
    int t = 0;
    forever begin
      @(negedge clk);
      if (h4.samp_s_ready) break;
      if (++t > 20) begin chk("samp_ready_timeout", 0, 1); break; end
    end
    tick();
  endtask

  // Coefficients are sent in host order c[0] first; c[0] is h[N-1].
  task automatic load4(input int c[N]);
    cq.delete(); ccyc.delete(); ld_at = 0;
    cfg4 = 1'b1; tick(); cfg4 = 1'b0;
    for (int i = 0; i < N; i++) begin
      h4.coeff_s_valid = 1'b1;
      h4.coeff_s_data  = DW'(c[i]);
      wait_c();
    end
    h4.coeff_s_valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < N; k++) ht[k] = c[N-1-k];
  endtask

  task automatic check_load(input string tag, input int c[N]);
    chk({tag, "_coeff_count"}, cq.size(), N);
    for (int i = 0; i < N && i < cq.size(); i++)
      chk($sformatf("%s_coeff%0d", tag, i), cq[i], c[i]);
    chk({tag, "_load_done_pos"}, ld_at, N);
    if (ccyc.size() == N) chk({tag, "_coeff_back_to_back"}, ccyc[N-1] - ccyc[0], N - 1);
    chk({tag, "_busy_after"}, busy4, 0);
  endtask

  task automatic send4(input int s[10], input int len, input bit gap,
                       input bit poke, input bit rgap);
    int t;
    xq.delete(); xcyc.delete(); fd_at.delete(); yq.delete();
    cr_seen = 0; watch_cr = 1;
    for (int i = 0; i < len; i++) begin
      if (rgap && $urandom_range(0, 2) == 0) begin
        h4.samp_s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      h4.samp_s_valid = 1'b1;
      h4.samp_s_data  = DW'(s[i]);
      h4.samp_s_last  = (i == len - 1);
      if (poke && i == 1) cfg4 = 1'b1;
      wait_s();
      cfg4 = 1'b0;
      if (gap && i != len - 1) begin
        h4.samp_s_valid = 1'b0;
        tick();
      end
    end
    h4.samp_s_valid = 1'b0;
    h4.samp_s_last  = 1'b0;
    if (poke) begin cfg4 = 1'b1; tick(); cfg4 = 1'b0; end
    t = 0;
    while (fd_at.size() == 0 && t < 40) begin tick(); t++; end
    if (fd_at.size() == 0) chk("frame_done_timeout", 0, 1);
    tick(); tick();
    watch_cr = 0;
  endtask

  task automatic check_frame(input string tag, input int s[10], input int len,
                             input int exp_len, input int exp_fd);
    int ye;
    chk({tag, "_beats"}, xq.size(), len + N - 1);
    for (int n = 0; n < len + N - 1 && n < xq.size(); n++)
      chk($sformatf("%s_x%0d", tag, n), xq[n], (n < len) ? s[n] : 0);
    chk({tag, "_frame_done_count"}, fd_at.size(), 1);
    if (fd_at.size() > 0) chk({tag, "_frame_done_beat"}, fd_at[0], exp_fd);
    chk({tag, "_frame_len"}, fl4, exp_len);
    chk({tag, "_busy_after"}, busy4, 0);
    chk({tag, "_coeff_ready_seen"}, cr_seen, 0);
    for (int n = 0; n < len + N - 1 && n < yq.size(); n++) begin
      ye = 0;
      for (int k = 0; k < N; k++)
        if (n - k >= 0 && n - k < len) ye += ht[k] * s[n-k];
      chk($sformatf("%s_y%0d", tag, n), yq[n], ye);
    end
  endtask

  typedef struct {
    int len;
    int s[10];
    bit gap;
    bit poke;
    int exp_len;
    int exp_fd;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int cv[N];
    int rs[10];
    int rl;
    bit gap_ok;

    tbl[0] = '{4, '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 1'b0, 4, 7};
    tbl[1] = '{3, '{5, 6, 7, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 3, 6};
    tbl[2] = '{9, '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0}, 1'b0, 1'b1, 7, 12};

    rst4 = 1'b1; rst1 = 1'b1; cfg4 = 1'b0; cfg1 = 1'b0;
    h4.coeff_s_valid = 1'b0; h4.coeff_s_data = '0;
    h4.samp_s_valid = 1'b0; h4.samp_s_data = '0; h4.samp_s_last = 1'b0;
    h1.coeff_s_valid = 1'b0; h1.coeff_s_data = '0;
    h1.samp_s_valid = 1'b0; h1.samp_s_data = '0; h1.samp_s_last = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_coeff_valid", cv4, 0);
    chk("rst_coeff_in", ci4, 0);
    chk("rst_input_valid", iv4, 0);
    chk("rst_x", x4, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_load_done", ld4, 0);
    chk("rst_frame_done", fd4, 0);
    chk("rst_frame_len", fl4, 0);
    chk("rst_coeff_ready", h4.coeff_s_ready, 0);
    chk("rst_samp_ready", h4.samp_s_ready, 0);
    tick();
    rst4 = 1'b0; rst1 = 1'b0;
    tick();

    // Idle: neither ready asserted.
    @(negedge clk);
    chk("idle_coeff_ready", h4.coeff_s_ready, 0);
    chk("idle_samp_ready", h4.samp_s_ready, 0);
    tick();

    cv = '{4, 3, 2, 1};
    load4(cv);
    check_load("load1", cv);

    for (int v = 0; v < 3; v++) begin
      send4(tbl[v].s, tbl[v].len, tbl[v].gap, tbl[v].poke, 1'b0);
      check_frame($sformatf("tbl%0d", v), tbl[v].s, tbl[v].len,
                  tbl[v].exp_len, tbl[v].exp_fd);
      if (tbl[v].gap) begin
        gap_ok = (xcyc.size() == tbl[v].len + N - 1);
        for (int i = 0; gap_ok && i + 1 < xcyc.size(); i++)
          if (xcyc[i+1] - xcyc[i] != ((i < tbl[v].len - 1) ? 2 : 1)) gap_ok = 0;
        chk($sformatf("tbl%0d_gap_pattern", v), gap_ok, 1);
      end
    end

    // Reset in the middle of a coefficient load.
    cfg4 = 1'b1; tick(); cfg4 = 1'b0;
    h4.coeff_s_valid = 1'b1; h4.coeff_s_data = 16'd11; wait_c();
    h4.coeff_s_data = 16'd12; wait_c();
    rst4 = 1'b1;
    @(negedge clk);
    chk("midrst_coeff_valid", cv4, 0);
    chk("midrst_coeff_in", ci4, 0);
    chk("midrst_busy", busy4, 0);
    chk("midrst_coeff_ready", h4.coeff_s_ready, 0);
    chk("midrst_frame_len", fl4, 0);
    chk("midrst_load_done", ld4, 0);
    h4.coeff_s_valid = 1'b0;
    tick();
    rst4 = 1'b0;
    tick();
    load4(cv);
    check_load("reload", cv);

    // Random coefficients and frames with random valid gaps.
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < N; i++) cv[i] = int'($urandom_range(0, 255));
      load4(cv);
      check_load($sformatf("rload%0d", it), cv);
      for (int f = 0; f < 2; f++) begin
        rl = int'($urandom_range(1, 9));
        for (int i = 0; i < 10; i++) rs[i] = int'($urandom_range(0, 1000));
        send4(rs, rl, 1'b0, 1'b0, 1'b1);
        check_frame($sformatf("rnd%0d_%0d", it, f), rs, rl,
                    (rl > 7) ? 7 : rl, rl + N - 1);
      end
    end
    chk("orphan_pulses", orphan, 0);

    // Single-tap instance: no flush, frame_done with the sample itself.
    cfg1 = 1'b1; tick(); cfg1 = 1'b0;
    h1.coeff_s_valid = 1'b1; h1.coeff_s_data = 16'd3;
    @(negedge clk);
    chk("n1_coeff_ready", h1.coeff_s_ready, 1);
    tick();
    h1.coeff_s_valid = 1'b0;
    @(negedge clk);
    chk("n1_coeff_valid", cv1, 1);
    chk("n1_coeff_in", ci1, 3);
    chk("n1_load_done", ld1, 1);
    chk("n1_busy_after_load", busy1, 0);
    tick();
    h1.samp_s_valid = 1'b1; h1.samp_s_data = 16'd2; h1.samp_s_last = 1'b1;
    tick();
    @(negedge clk);
    chk("n1_samp_ready", h1.samp_s_ready, 1);
    tick();
    h1.samp_s_valid = 1'b0; h1.samp_s_last = 1'b0;
    @(negedge clk);
    chk("n1_input_valid", iv1, 1);
    chk("n1_x", x1, 2);
    chk("n1_frame_done", fd1, 1);
    chk("n1_busy", busy1, 0);
    chk("n1_frame_len", fl1, 1);
    chk("n1_y", int'(ci1) * int'(x1), 6);
    @(negedge clk);
    chk("n1_no_flush", iv1, 0);
    chk("n1_frame_done_once", fd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_stream_driver.md
# fir_stream_driver

Upstream transmitter for `fir_filter`: accepts coefficient and sample streams from a host-side ready/valid interface and drives the filter's coefficient shift port and sample port. It loads exactly NUM_TAPS coefficients per load command, streams a sample frame, then flushes NUM_TAPS-1 zero samples so the full convolution tail emerges at the filter output. It sits between the UMI register/FIFO front end and `fir_filter`, and contains the only control FSM in the filter datapath.

## Interface
- DATA_WIDTH, 16, width of samples and coefficients
- NUM_TAPS, 16, filter length; must be ≥1 and match the `fir_filter` instance
- CNT_WIDTH, 32, width of `frame_len`
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_load  in  1  single-cycle pulse: start a coefficient load
- coeff_s_valid / coeff_s_ready  in / out  1 / 1  coefficient stream handshake
- coeff_s_data  in  DATA_WIDTH  coefficient word; send h[NUM_TAPS-1] first and h[0] last
- samp_s_valid / samp_s_ready  in / out  1 / 1  sample stream handshake
- samp_s_data  in  DATA_WIDTH  sample word
- samp_s_last  in  1  marks the final sample of a frame
- coeff_valid, coeff_in  out  1, DATA_WIDTH  to filter coefficient shift port
- input_valid, x  out  1, DATA_WIDTH  to filter sample port
- busy  out  1  state ≠ IDLE
- load_done  out  1  one-cycle pulse at coefficient load completion
- frame_done  out  1  one-cycle pulse on the last flush beat
- frame_len  out  CNT_WIDTH  samples accepted in the current or most recent frame

## Operation
- States: IDLE, LOAD, STREAM, FLUSH. A single counter `cnt` (clog2(NUM_TAPS)+1 bits) serves LOAD and FLUSH.
- IDLE: both ready signals are 0.
  - `cfg_load` → LOAD, `cnt`=0.
  - Otherwise, `samp_s_valid` → STREAM and `frame_len`=0. No beat is accepted in the transition cycle.
  - `cfg_load` has priority over `samp_s_valid`.
- LOAD: `coeff_s_ready`=1.
  - Each handshake registers `coeff_valid`=1 and `coeff_in`=data, then increments `cnt`.
  - The handshake at `cnt`==NUM_TAPS-1 → IDLE and pulses `load_done`.
  - `cfg_load` is ignored while in LOAD.
- STREAM: `samp_s_ready`=1.
  - Each handshake registers `input_valid`=1 and `x`=data, then increments `frame_len` (saturates at all-ones).
  - A handshake with `samp_s_last` → FLUSH with `cnt`=0. If NUM_TAPS==1, it goes to IDLE instead and pulses `frame_done` with that beat.
  - `cfg_load` is ignored in STREAM.
- FLUSH: ready signals are 0. Every cycle registers `input_valid`=1 and `x`=0, then increments `cnt`.
  - The cycle with `cnt`==NUM_TAPS-2 → IDLE and registers `frame_done`=1.
  - Exactly NUM_TAPS-1 zero beats are emitted.
- When there is no handshake or flush beat, `coeff_valid` and `input_valid` are 0 next cycle. `x` and `coeff_in` hold their last value.
- Ready signals are combinational from state only and never depend on valid.
- Reset, including mid-LOAD or mid-STREAM:
  - State → IDLE; `cnt`, `frame_len`, and all outputs → 0.
  - Partially shifted coefficients inside the filter are not this block's concern. The host must reissue `cfg_load`.

## Timing
- All outputs except the ready signals are registered. Reset value of every output is 0.
- A handshake in cycle N drives `coeff_valid`/`input_valid` in cycle N+1.
- The filter asserts `output_valid`, with the corresponding `y`, in N+3.
- Throughput is one beat per cycle in LOAD and STREAM.
- A frame of L samples occupies L+NUM_TAPS-1 filter input beats, plus one IDLE→STREAM entry cycle.
- `load_done` is high in the same cycle as the final `coeff_valid`.
- `frame_done` is high in the same cycle as the final zero `x`.

## Structure
- Shared package `fir_pkg`:
  - state encodings as localparams (IDLE=0, LOAD=1, STREAM=2, FLUSH=3);
  - a function returning the `cnt` width from NUM_TAPS.
  - `fir_filter` harness parameters are also shared from this package.
- No sub-module: the block is one flat FSM with its counters.
- The integration wrapper `fir_system` instantiates `fir_stream_driver` and `fir_filter` side by side.

## Test plan
- NUM_TAPS=4: `cfg_load`, then coefficients 4,3,2,1 back-to-back.
  - `coeff_in` = 4,3,2,1 on consecutive cycles.
  - `load_done` pulses with the 1.
  - Returns to IDLE; `busy`=0.
- After that load, stream 1,0,0,0 with last on the fourth sample.
  - `x` = 1,0,0,0 followed by three flush zeros.
  - Filter `y` = 1,2,3,4,0,0,0.
  - `frame_done` on the seventh beat; `frame_len`=4.
- `samp_s_valid` asserted only every other cycle for samples 5,6,7(last).
  - `input_valid` has gaps matching the gaps in `samp_s_valid`.
  - No beat is duplicated or dropped.
  - Exactly 3 flush beats follow.
- Assert `reset` after 2 of 4 coefficient beats.
  - All outputs go to 0 and state is IDLE on the next cycle.
  - A fresh load of 4 beats then completes normally.
- Pulse `cfg_load` during STREAM and again during FLUSH.
  - Both are ignored; `coeff_s_ready` stays 0.
  - The frame completes unchanged.
- NUM_TAPS=1, coefficient 3, stream 2(last).
  - No FLUSH state is entered.
  - `frame_done` is coincident with `x`=2.
  - Filter `y`=6.
